// File: rtl/regfile_pkg.sv
// Shared defaults for the P_Risc integer register file and scoreboard.
package regfile_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int NRD_DEF  = 2;

    // Address width for a register count (NREG is a power of two, >= 2).
    function automatic int aw_of(input int nreg);
        return $clog2(nreg);
    endfunction

endpackage

// File: rtl/regfile_rport.sv
// One read port: x0 forcing, write-back bypass and RAW stall flag.
module regfile_rport #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic [AW-1:0]              ra,
    input  logic                       we,
    input  logic [AW-1:0]              wa,
    input  logic [XLEN-1:0]            wd,
    input  logic [NREG-1:1][XLEN-1:0]  mem,
    input  logic [NREG-1:1]            pend,
    output logic [XLEN-1:0]            rd,
    output logic                       rbusy
);

    logic nonzero;
    logic wb_hit;

    always_comb begin
        nonzero = (ra != '0);
        wb_hit  = we && (wa == ra);
        rd      = '0;
        rbusy   = 1'b0;
        if (nonzero) begin
            rd    = wb_hit ? wd : mem[ra];
            // A write-back landing this cycle releases the stall; bypass carries the data.
            rbusy = pend[ra] && !wb_hit;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with per-register pending bits for RAW stall detection.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int XLEN = XLEN_DEF,
    parameter  int NREG = NREG_DEF,
    parameter  int NRD  = NRD_DEF,
    localparam int AW   = aw_of(NREG)
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [NRD*AW-1:0]   RA,
    output logic [NRD*XLEN-1:0] RD,
    output logic [NRD-1:0]      RBUSY,
    input  logic                WE,
    input  logic [AW-1:0]       WA,
    input  logic [XLEN-1:0]     WD,
    input  logic                ISS,
    input  logic [AW-1:0]       ISS_RD,
    input  logic                FLUSH,
    output logic                ANY_BUSY
);

    logic [NREG-1:1][XLEN-1:0] mem;
    logic [NREG-1:1]           pend;
    logic [NREG-1:1]           pend_nxt;
    logic                      any_busy_q;
    logic                      wr_ok;

    assign wr_ok = WE && (WA != '0);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mem <= '0;
        end else if (wr_ok) begin
            mem[WA] <= WD;
        end
    end

    // Issue is applied after the clear so a newer producer keeps ownership.
    always_comb begin
        pend_nxt = pend;
        if (FLUSH) begin
            pend_nxt = '0;
        end else begin
            if (wr_ok)
                pend_nxt[WA] = 1'b0;
            if (ISS && (ISS_RD != '0))
                pend_nxt[ISS_RD] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pend       <= '0;
            any_busy_q <= 1'b0;
        end else begin
            pend       <= pend_nxt;
            any_busy_q <= |pend_nxt;
        end
    end

    assign ANY_BUSY = any_busy_q;

    for (genvar i = 0; i < NRD; i++) begin : g_rport
        regfile_rport #(
            .XLEN (XLEN),
            .NREG (NREG),
            .AW   (AW)
        ) u_rport (
            .ra    (RA[i*AW +: AW]),
            .we    (WE),
            .wa    (WA),
            .wd    (WD),
            .mem   (mem),
            .pend  (pend),
            .rd    (RD[i*XLEN +: XLEN]),
            .rbusy (RBUSY[i])
        );
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb with a queue-based scoreboard and negedge monitor.
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;

    logic                CLK;
    logic                RST_N;
    logic [NRD*AW-1:0]   RA;
    logic [NRD*XLEN-1:0] RD;
    logic [NRD-1:0]      RBUSY;
    logic                WE;
    logic [AW-1:0]       WA;
    logic [XLEN-1:0]     WD;
    logic                ISS;
    logic [AW-1:0]       ISS_RD;
    logic                FLUSH;
    logic                ANY_BUSY;

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .RA       (RA),
        .RD       (RD),
        .RBUSY    (RBUSY),
        .WE       (WE),
        .WA       (WA),
        .WD       (WD),
        .ISS      (ISS),
        .ISS_RD   (ISS_RD),
        .FLUSH    (FLUSH),
        .ANY_BUSY (ANY_BUSY)
    );

    typedef struct {
        string       tag;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [1:0]  rbusy;
        logic        any;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // Monitor: outputs are combinational, so the scoreboard entry for a cycle is checked mid-cycle.
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.tag, ".rd0"},   RD[31:0],         e.rd0);
            chk({e.tag, ".rd1"},   RD[63:32],        e.rd1);
            chk({e.tag, ".rbusy"}, {30'd0, RBUSY},   {30'd0, e.rbusy});
            chk({e.tag, ".any"},   {31'd0, ANY_BUSY}, {31'd0, e.any});
        end
    end

    task automatic step(input string tag, input logic rst,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic iss, input logic [4:0] ird, input logic fl,
                        input logic [4:0] a0, input logic [4:0] a1,
                        input logic [31:0] e0, input logic [31:0] e1,
                        input logic [1:0] erb, input logic eany);
        exp_t e;
        @(posedge CLK);
        #1;
        RST_N = rst; WE = we; WA = wa; WD = wd;
        ISS = iss; ISS_RD = ird; FLUSH = fl;
        RA = {a1, a0};
        e.tag = tag; e.rd0 = e0; e.rd1 = e1; e.rbusy = erb; e.any = eany;
        exp_q.push_back(e);
    endtask

    initial begin
        int budget;
        RST_N = 1'b1; WE = 1'b0; WA = '0; WD = '0;
        ISS = 1'b0; ISS_RD = '0; FLUSH = 1'b0; RA = '0;
        #1 RST_N = 1'b0;

        //    tag        rst we wa  wd            iss ird fl a0  a1  rd0           rd1           rb     any
        step("rst_byp",  0, 1, 5,  32'h1111,     0,  0,  0, 5,  0,  32'h1111,     32'h0,        2'b00, 0);
        step("rst_rd",   0, 0, 0,  32'h0,        0,  0,  0, 5,  0,  32'h0,        32'h0,        2'b00, 0);
        step("wr_byp",   1, 1, 5,  32'hDEADBEEF, 0,  0,  0, 5,  0,  32'hDEADBEEF, 32'h0,        2'b00, 0);
        step("wr_mem",   1, 0, 0,  32'h0,        0,  0,  0, 5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 0);
        step("x0_wr",    1, 1, 0,  32'h1234,     1,  0,  0, 0,  5,  32'h0,        32'hDEADBEEF, 2'b00, 0);
        step("x0_after", 1, 0, 0,  32'h0,        0,  0,  0, 0,  0,  32'h0,        32'h0,        2'b00, 0);
        step("iss7",     1, 0, 0,  32'h0,        1,  7,  0, 7,  5,  32'h0,        32'hDEADBEEF, 2'b00, 0);
        step("busy7",    1, 0, 0,  32'h0,        0,  0,  0, 7,  5,  32'h0,        32'hDEADBEEF, 2'b01, 1);
        step("wb7",      1, 1, 7,  32'h55,       0,  0,  0, 7,  7,  32'h55,       32'h55,       2'b00, 1);
        step("clr7",     1, 0, 0,  32'h0,        0,  0,  0, 7,  0,  32'h55,       32'h0,        2'b00, 0);
        step("iss_wb3",  1, 1, 3,  32'hA5A5,     1,  3,  0, 3,  7,  32'hA5A5,     32'h55,       2'b00, 0);
        step("keep3",    1, 0, 0,  32'h0,        0,  0,  0, 3,  0,  32'hA5A5,     32'h0,        2'b01, 1);
        step("flush",    1, 0, 0,  32'h0,        1,  4,  1, 4,  3,  32'h0,        32'hA5A5,     2'b10, 1);
        step("flushed",  1, 0, 0,  32'h0,        0,  0,  0, 4,  3,  32'h0,        32'hA5A5,     2'b00, 0);
        step("iss_wb2",  1, 1, 2,  32'h99,       1,  2,  0, 2,  3,  32'h99,       32'hA5A5,     2'b00, 0);
        step("busy2",    1, 0, 0,  32'h0,        0,  0,  0, 2,  0,  32'h99,       32'h0,        2'b01, 1);
        // Reset pulsed low between edges; checked before the next edge.
        step("arst",     0, 0, 0,  32'h0,        0,  0,  0, 2,  3,  32'h0,        32'h0,        2'b00, 0);
        @(negedge CLK);
        #1 RST_N = 1'b1;
        step("post_rst", 1, 0, 0,  32'h0,        0,  0,  0, 2,  7,  32'h0,        32'h0,        2'b00, 0);

        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge CLK);
            budget++;
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending entries want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with an integrated busy scoreboard for the pipelined P_Risc core. It has configurable data width, register count and number of read ports. Writes occur on the rising edge, and reads bypass a same-cycle write. Each register carries a pending bit, set when a producing instruction issues and cleared when that instruction writes back, so decode can stall on RAW hazards. Register 0 is hardwired to zero and is never pending.

## Interface
- XLEN, 32: data width in bits.
- NREG, 32: register count (power of two, ≥2).
- NRD, 2: read port count (1..4).
- AW, $clog2(NREG): address width (derived, not overridden).
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- RA  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW].
- RD  out  NRD*XLEN  read data; port i occupies bits [i*XLEN +: XLEN].
- RBUSY  out  NRD  port i's register has a pending write.
- WE  in  1  write-back enable.
- WA  in  AW  write-back address.
- WD  in  XLEN  write-back data.
- ISS  in  1  an instruction writing a register issues this cycle.
- ISS_RD  in  AW  destination register of the issuing instruction.
- FLUSH  in  1  clear all pending bits (pipeline flush); register data is kept.
- ANY_BUSY  out  1  OR of all pending bits.

## Operation
- Storage covers entries 1..NREG-1 only. A write to address 0 is discarded. A read of address 0 returns 0 with RBUSY=0.
- Read (combinational):
  - If WE && WA==RA[i] && WA!=0, RD[i]=WD (write-through bypass).
  - Otherwise RD[i]=mem[RA[i]].
- Write: on a rising edge with WE && WA!=0, mem[WA] <= WD.
- Pending bits pend[1..NREG-1], updated on the rising edge in this priority order:
  - FLUSH=1: every bit is cleared. ISS is ignored that cycle. WE still writes data.
  - ISS && ISS_RD!=0: pend[ISS_RD] <= 1. This wins over a same-cycle clear of the same register, because the newer producer owns it.
  - WE && WA!=0: pend[WA] <= 0.
- RBUSY[i] (combinational):
  - Equals pend[RA[i]] && !(WE && WA==RA[i]).
  - A same-cycle write-back therefore releases the stall, and the bypass supplies the data.
  - ISS in the same cycle does not raise RBUSY until the next cycle.
- ANY_BUSY is the registered OR of the pend vector, with no bypass terms.
- WE with pend[WA]=0 (write-back with no issue record) is legal: data is written and the pending bit stays 0.

## Timing
- Reset (RST_N=0, asynchronous): mem[1..NREG-1]=0 and pend=0.
- Outputs while in reset:
  - RD = 0 on every port. The bypass is still active, so a port reading the same nonzero address as an active write shows WD.
  - RBUSY=0.
  - ANY_BUSY=0.
- Reset deassertion is synchronised by the system. The first edge after release may write.
- Read latency 0: RD and RBUSY are combinational from RA, WE, WA, WD and state.
- Write latency 1: data is visible from mem on the edge after WE. It is visible through the bypass in the same cycle.
- Pending latency 1: pend is set or cleared at the edge that samples ISS or WE.
- Back-to-back ISS to the same register keeps pend=1. Only the single write-back that follows clears it. Multiple outstanding producers are the decode stage's responsibility.
- Reset asserted mid-operation clears all pending state immediately. In-flight writes are lost.

## Structure
- Shared package regfile_pkg holds the XLEN, NREG and NRD defaults plus the AW derivation function.
- One sub-module, regfile_rport, is instantiated NRD times via generate. It contains the address-0 check, the bypass mux and the RBUSY logic.
- The top holds the mem array, the pend vector and the ANY_BUSY register.

## Test plan
- Reset then read: RST_N low, RA = {5, 0} → RD = {0, 0}, RBUSY = 0, ANY_BUSY = 0.
- Write/read: WE, WA=5, WD=0xDEADBEEF, RA[0]=5 in the same cycle → RD[0]=0xDEADBEEF (bypass). Next cycle with WE=0 → RD[0] still 0xDEADBEEF.
- x0 immutability: WE, WA=0, WD=0x1234, plus ISS with ISS_RD=0 → RD for address 0 stays 0, RBUSY=0, ANY_BUSY=0.
- Scoreboard:
  - ISS with ISS_RD=7 → next cycle RBUSY for RA=7 is 1 and ANY_BUSY=1.
  - WE, WA=7, WD=0x55 → RBUSY=0 and RD=0x55 in that cycle.
  - pend clears on the edge, and ANY_BUSY=0 one cycle later.
- Simultaneous events:
  - ISS with ISS_RD=3 plus WE with WA=3 → pend[3]=1 afterwards and mem[3] updated.
  - FLUSH with ISS with ISS_RD=4 → all pending bits 0, pend[4]=0.
- Async reset mid-run: pend[2]=1 and mem[2]=0x99, then RST_N pulsed low between edges → RD for address 2 is 0 and RBUSY=0 immediately, before the next edge.
